axim: RTL and testbench
=======================

AXIM -- requirements
Module: axim

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 i_clk  in  1  clock; all state updates on the rising edge.
REQ-003 i_rst  in  1  synchronous active-high reset.
REQ-004 hs_ls4axim_val  in  1  load/store unit request valid; payload held stable until hs_axim4ls_rdy.
REQ-005 hs_axim4ls_rdy  out  1  one-cycle completion pulse to the load/store unit.
REQ-006 i_adr  in  32  request byte address.
REQ-007 i_wdat  in  32  store data.
REQ-008 i_wen  in  4  byte write enables; nonzero means write.
REQ-009 i_ren  in  1  read request.
REQ-010 o_rdat  out  32  read data; valid while hs_axim4ls_rdy=1.
REQ-011 o_axi_adr  out  32  registered address shared by AW and AR.
REQ-012 o_awvalid  out  1 / i_awready  in  1  AXI4-Lite write-address handshake.
REQ-013 o_wvalid  out  1 / i_wready  in  1  AXI4-Lite write-data handshake.
REQ-014 o_wdata  out  32 / o_wstrb  out  4  registered write data and strobes.
REQ-015 i_bvalid  in  1 / o_bready  out  1 / i_bresp  in  2  write response.
REQ-016 o_arvalid  out  1 / i_arready  in  1  read-address handshake.
REQ-017 i_rvalid  in  1 / o_rready  out  1 / i_rdata  in  32 / i_rresp  in  2  read data channel.
REQ-018 o_bus_err  out  1  sticky error flag; present only with CIRNO9_AXIM_ERR_EN.

Function
REQ-019 The FSM SHALL have the states IDLE, WR, WRESP, RD, RDATA and DONE, and SHALL keep at most one transaction outstanding.
REQ-020 In IDLE, when hs_ls4axim_val=1, the block SHALL latch adr, wdat and wen. If wen!=0, it SHALL go to WR (write wins over ren). Otherwise, if ren=1, it SHALL go to RD. Otherwise it SHALL go to DONE with rdat=0.
REQ-021 WR SHALL assert awvalid and wvalid together. Each SHALL deassert after its own handshake, tracked by independent aw_done and w_done flags. The FSM SHALL enter WRESP once both flags are set, including the case where both handshakes occur in the same cycle.
REQ-022 WRESP SHALL assert bready. On bvalid it SHALL go to DONE.
REQ-023 RD SHALL assert arvalid until arready, then go to RDATA.
REQ-024 RDATA SHALL assert rready. On rvalid it SHALL register rdata into o_rdat and go to DONE.
REQ-025 DONE SHALL assert hs_axim4ls_rdy for exactly one cycle and then return to IDLE. A new request SHALL NOT be sampled in DONE.
REQ-026 Minimum latency with all ready and valid responses immediate: request sampled at cycle 0, AXI valid in cycle 1, response in cycle 2, rdy in cycle 3.
REQ-027 AXI valid signals SHALL NOT depend combinationally on any AXI ready; address, data and strobe SHALL stay stable while valid is high.
REQ-028 o_rdat SHALL hold its last value outside DONE. A write SHALL NOT modify o_rdat.

Reset
REQ-029 On reset the FSM SHALL go to IDLE, and all valid, ready, rdy, o_rdat, o_axi_adr, o_wdata, o_wstrb, the aw/w flags and o_bus_err SHALL be 0.
REQ-030 Reset mid-transaction SHALL abandon the transaction with no completion pulse. The AXI slave is reset together with this block.

Configuration
REQ-031 With CIRNO9_AXIM_ERR_EN defined, bresp!=0 or rresp!=0 at its handshake SHALL set o_bus_err until reset, and the transaction SHALL still complete normally; without the macro, the port is absent and resp is ignored.

Structure
REQ-032 The FSM state encodings, the AXI resp code OKAY=2'b00 and CIRNO9_AXIM_ERR_EN SHALL live in cirno9_define.v; the design is a single module with no sub-module.

Verification
REQ-033 Read 0x4000_0010, arready and rvalid immediate, rdata=0xCAFE_F00D -> rdy at cycle 3, o_rdat=0xCAFE_F00D, one arvalid cycle.
REQ-034 Write 0x4000_0004, wen=4'b0011, wdat=0x1234_5678, awready delayed 3 cycles, wready immediate -> wvalid drops after cycle 1, awvalid held stable, one rdy after bvalid.
REQ-035 Request with wen=0 and ren=0 -> no AXI activity, rdy at cycle 2, o_rdat=0.
REQ-036 Reset asserted in RDATA, with rvalid arriving after reset -> no rdy, FSM IDLE, all outputs 0.
REQ-037 ERR_EN: read returns rresp=2'b10 -> o_bus_err=1 and stays 1 across later OKAY transactions until reset.
REQ-038 Back-to-back requests, val held high -> second request sampled in the IDLE cycle after DONE, never in DONE itself.

Source files
------------

// File: rtl/axim_pkg.sv
// Shared encodings for the axim AXI4-Lite master: FSM state codes and AXI response codes.
package axim_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WR    = 3'd1,
      ST_WRESP = 3'd2,
      ST_RD    = 3'd3,
      ST_RDATA = 3'd4,
      ST_DONE  = 3'd5
   } axim_state_e;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != AXI_RESP_OKAY;
   endfunction

endpackage

// File: rtl/axim.sv
// Single-outstanding AXI4-Lite master bridging a load/store unit request to AW/W/B or AR/R.
// Optional sticky bus-error flag o_bus_err is built only when CIRNO9_AXIM_ERR_EN is defined.
module axim
   import axim_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        hs_ls4axim_val,
   output logic        hs_axim4ls_rdy,
   input  logic [31:0] i_adr,
   input  logic [31:0] i_wdat,
   input  logic [3:0]  i_wen,
   input  logic        i_ren,
   output logic [31:0] o_rdat,
   output logic [31:0] o_axi_adr,
   output logic        o_awvalid,
   input  logic        i_awready,
   output logic        o_wvalid,
   input  logic        i_wready,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_wstrb,
   input  logic        i_bvalid,
   output logic        o_bready,
   input  logic [1:0]  i_bresp,
   output logic        o_arvalid,
   input  logic        i_arready,
   input  logic        i_rvalid,
   output logic        o_rready,
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_rresp,
`ifdef CIRNO9_AXIM_ERR_EN
   output logic        o_bus_err,
`endif
   output logic [2:0]  o_dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
   // Valids are registered and never look at the same-cycle ready.
   axim_state_e state_q;
   logic        nop_q;
   logic [31:0] adr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        awvalid_q;
   logic        wvalid_q;
   logic        aw_done_q;
   logic        w_done_q;
   logic        bready_q;
   logic        arvalid_q;
   logic        rready_q;
   logic        rdy_q;
   logic [31:0] rdat_q;

   logic        aw_done_d;
   logic        w_done_d;

   // A flag counts as done in the cycle its handshake fires, so AW and W completing together
   // still leave WR after one cycle.
   assign aw_done_d = aw_done_q | (awvalid_q & i_awready);
   assign w_done_d  = w_done_q  | (wvalid_q  & i_wready);

`ifdef CIRNO9_AXIM_ERR_EN
   logic err_q;
   assign o_bus_err = err_q;
`else
   logic unused_resp;
   assign unused_resp = ^{i_bresp, i_rresp};
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         nop_q     <= 1'b0;
         adr_q     <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         rdy_q     <= 1'b0;
         rdat_q    <= '0;
`ifdef CIRNO9_AXIM_ERR_EN
         err_q     <= 1'b0;
`endif
      end else begin
         rdy_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (nop_q) begin
                  // Request with neither read nor write: settle one cycle, then answer with zero data.
                  nop_q   <= 1'b0;
                  rdat_q  <= '0;
                  rdy_q   <= 1'b1;
                  state_q <= ST_DONE;
               end else if (hs_ls4axim_val) begin
                  adr_q   <= i_adr;
                  wdata_q <= i_wdat;
                  wstrb_q <= i_wen;
                  if (i_wen != 4'b0000) begin
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     aw_done_q <= 1'b0;
                     w_done_q  <= 1'b0;
                     state_q   <= ST_WR;
                  end else if (i_ren) begin
                     arvalid_q <= 1'b1;
                     state_q   <= ST_RD;
                  end else begin
                     nop_q <= 1'b1;
                  end
               end
            end
            ST_WR: begin
               aw_done_q <= aw_done_d;
               w_done_q  <= w_done_d;
               if (awvalid_q && i_awready) awvalid_q <= 1'b0;
               if (wvalid_q && i_wready)   wvalid_q  <= 1'b0;
               if (aw_done_d && w_done_d) begin
                  bready_q <= 1'b1;
                  state_q  <= ST_WRESP;
               end
            end
            ST_WRESP: begin
               if (i_bvalid) begin
                  bready_q <= 1'b0;
                  rdy_q    <= 1'b1;
                  state_q  <= ST_DONE;
`ifdef CIRNO9_AXIM_ERR_EN
                  if (resp_is_err(i_bresp)) err_q <= 1'b1;
`endif
               end
            end
            ST_RD: begin
               if (i_arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= ST_RDATA;
               end
            end
            ST_RDATA: begin
               if (i_rvalid) begin
                  rready_q <= 1'b0;
                  rdat_q   <= i_rdata;
                  rdy_q    <= 1'b1;
                  state_q  <= ST_DONE;
`ifdef CIRNO9_AXIM_ERR_EN
                  if (resp_is_err(i_rresp)) err_q <= 1'b1;
`endif
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign hs_axim4ls_rdy = rdy_q;
   assign o_rdat         = rdat_q;
   assign o_axi_adr      = adr_q;
   assign o_awvalid      = awvalid_q;
   assign o_wvalid       = wvalid_q;
   assign o_wdata        = wdata_q;
   assign o_wstrb        = wstrb_q;
   assign o_bready       = bready_q;
   assign o_arvalid      = arvalid_q;
   assign o_rready       = rready_q;
   assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_axim.sv
// Directed bench for axim: a vector table of single transactions against a delay-programmable
// AXI slave, plus hand-written reset, back-to-back and (with CIRNO9_AXIM_ERR_EN) error sequences.
module tb_axim;
   import axim_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        val = 1'b0;
   logic        hs_rdy;
   logic [31:0] adr = '0;
   logic [31:0] wdat = '0;
   logic [3:0]  wen = '0;
   logic        ren = 1'b0;
   logic [31:0] o_rdat;
   logic [31:0] o_axi_adr;
   logic        o_awvalid;
   logic        awready = 1'b0;
   logic        o_wvalid;
   logic        wready = 1'b0;
   logic [31:0] o_wdata;
   logic [3:0]  o_wstrb;
   logic        bvalid = 1'b0;
   logic        o_bready;
   logic [1:0]  bresp = 2'b00;
   logic        o_arvalid;
   logic        arready = 1'b0;
   logic        rvalid = 1'b0;
   logic        o_rready;
   logic [31:0] rdata = '0;
   logic [1:0]  rresp = 2'b00;
   logic [2:0]  o_dbg_state;
`ifdef CIRNO9_AXIM_ERR_EN
   logic        o_bus_err;
`endif

   logic [1:0]  rresp_drv = 2'b00;
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   axim dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .hs_ls4axim_val (val),
      .hs_axim4ls_rdy (hs_rdy),
      .i_adr          (adr),
      .i_wdat         (wdat),
      .i_wen          (wen),
      .i_ren          (ren),
      .o_rdat         (o_rdat),
      .o_axi_adr      (o_axi_adr),
      .o_awvalid      (o_awvalid),
      .i_awready      (awready),
      .o_wvalid       (o_wvalid),
      .i_wready       (wready),
      .o_wdata        (o_wdata),
      .o_wstrb        (o_wstrb),
      .i_bvalid       (bvalid),
      .o_bready       (o_bready),
      .i_bresp        (bresp),
      .o_arvalid      (o_arvalid),
      .i_arready      (arready),
      .i_rvalid       (rvalid),
      .o_rready       (o_rready),
      .i_rdata        (rdata),
      .i_rresp        (rresp),
`ifdef CIRNO9_AXIM_ERR_EN
      .o_bus_err      (o_bus_err),
`endif
      .o_dbg_state    (o_dbg_state)
   );

   typedef struct {
      logic [31:0] adr;
      logic [31:0] wdat;
      logic [3:0]  wen;
      logic        ren;
      logic [31:0] rdata;
      int          aw_dly;
      int          w_dly;
      int          b_dly;
      int          ar_dly;
      int          r_dly;
      int          exp_cyc;
      int          exp_aw;
      int          exp_w;
      int          exp_ar;
      logic [31:0] exp_rdat;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic slave_idle();
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      arready = 1'b0;
      rvalid  = 1'b0;
      rresp   = 2'b00;
   endtask

   task automatic check_all_zero(input string name);
      check(name, {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, hs_rdy,
                   o_rdat, o_axi_adr, o_wdata, o_wstrb}, 64'h0);
      check({name, "_rdat_adr"}, {o_rdat, o_axi_adr}, 64'h0);
      check({name, "_state"}, o_dbg_state, ST_IDLE);
   endtask

   // One transaction from the IDLE cycle (cycle 0) until the cycle after the completion pulse.
   task automatic run_txn(input vec_t v, input string tag);
      int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
      int rdy_n = 0, rdy_c = -1;
      bit fin = 0;
      val = 1'b1; adr = v.adr; wdat = v.wdat; wen = v.wen; ren = v.ren; rdata = v.rdata;
      for (int c = 0; c < 40 && !fin; c++) begin
         if (o_awvalid || o_arvalid) check({tag, "_adr_stable"}, o_axi_adr, v.adr);
         if (o_wvalid) check({tag, "_wdata_stable"}, {o_wdata, o_wstrb}, {v.wdat, v.wen});
         if (o_awvalid) begin aw_n++; awready = (aw_n > v.aw_dly); end else awready = 1'b0;
         if (o_wvalid)  begin w_n++;  wready  = (w_n  > v.w_dly);  end else wready  = 1'b0;
         if (o_bready)  begin b_n++;  bvalid  = (b_n  > v.b_dly);  end else bvalid  = 1'b0;
         if (o_arvalid) begin ar_n++; arready = (ar_n > v.ar_dly); end else arready = 1'b0;
         if (o_rready)  begin r_n++;  rvalid  = (r_n  > v.r_dly);  end else rvalid  = 1'b0;
         rresp = rvalid ? rresp_drv : 2'b00;
         if (rdy_n > 0 && c == rdy_c + 1) begin
            check({tag, "_rdy_pulse_len"}, hs_rdy, 1'b0);
            check({tag, "_back_idle"}, o_dbg_state, ST_IDLE);
            fin = 1;
         end else if (hs_rdy) begin
            rdy_n++;
            if (rdy_n == 1) rdy_c = c;
            check({tag, "_rdat"}, o_rdat, v.exp_rdat);
            val = 1'b0;
         end
         if (!fin) tick();
      end
      slave_idle();
      val = 1'b0;
      check({tag, "_rdy_count"}, rdy_n, 1);
      check({tag, "_rdy_cycle"}, rdy_c, v.exp_cyc);
      check({tag, "_aw_cycles"}, aw_n, v.exp_aw);
      check({tag, "_w_cycles"}, w_n, v.exp_w);
      check({tag, "_ar_cycles"}, ar_n, v.exp_ar);
   endtask

   initial begin
      vec_t ve;
      // adr, wdat, wen, ren, rdata, aw/w/b/ar/r delays, rdy cycle, aw/w/ar valid cycles, o_rdat
      vecs[0] = '{32'h4000_0010, 32'h0000_0000, 4'b0000, 1'b1, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 3, 0, 0, 1, 32'hCAFE_F00D};
      vecs[1] = '{32'h4000_0004, 32'h1234_5678, 4'b0011, 1'b0, 32'hDEAD_0000, 3, 0, 0, 0, 0, 6, 4, 1, 0, 32'hCAFE_F00D};
      vecs[2] = '{32'h4000_0020, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h5555_5555, 0, 0, 0, 0, 0, 2, 0, 0, 0, 32'h0000_0000};
      vecs[3] = '{32'h4000_0100, 32'h0000_0000, 4'b0000, 1'b1, 32'h0BAD_BEEF, 0, 0, 0, 2, 1, 6, 0, 0, 3, 32'h0BAD_BEEF};
      vecs[4] = '{32'h4000_0200, 32'hA5A5_5A5A, 4'b1111, 1'b0, 32'h1111_1111, 1, 1, 2, 0, 0, 6, 2, 2, 0, 32'h0BAD_BEEF};
      vecs[5] = '{32'h4000_0300, 32'h0000_00FF, 4'b0001, 1'b0, 32'h2222_2222, 0, 2, 0, 0, 0, 5, 1, 3, 0, 32'h0BAD_BEEF};
      vecs[6] = '{32'h4000_0400, 32'h1111_2222, 4'b1000, 1'b1, 32'h7777_7777, 0, 0, 0, 0, 0, 3, 1, 1, 0, 32'h0BAD_BEEF};
      vecs[7] = '{32'h4000_0008, 32'h0000_0000, 4'b0000, 1'b1, 32'h8000_0001, 0, 0, 0, 0, 0, 3, 0, 0, 1, 32'h8000_0001};

      repeat (3) tick();
      check_all_zero("reset");
`ifdef CIRNO9_AXIM_ERR_EN
      check("reset_bus_err", o_bus_err, 1'b0);
`endif
      rst = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

      // Back-to-back reads with val held high across the completion pulse.
      val = 1'b1; wen = 4'b0000; ren = 1'b1; adr = 32'h4000_1000; rdata = 32'h0000_AAAA;
      for (int c = 0; c < 9; c++) begin
         check($sformatf("b2b_arvalid_c%0d", c), o_arvalid, (c == 1 || c == 5));
         check($sformatf("b2b_rdy_c%0d", c), hs_rdy, (c == 3 || c == 7));
         arready = o_arvalid;
         rvalid  = o_rready;
         if (c == 3) begin
            check("b2b_rdat_first", o_rdat, 32'h0000_AAAA);
            adr = 32'h4000_2000; rdata = 32'h0000_BBBB;
         end
         if (c == 4) check("b2b_idle_after_done", o_dbg_state, ST_IDLE);
         if (c == 5) check("b2b_second_adr", o_axi_adr, 32'h4000_2000);
         if (c == 7) begin
            check("b2b_rdat_second", o_rdat, 32'h0000_BBBB);
            val = 1'b0;
         end
         tick();
      end
      slave_idle();

      // Reset while waiting in RDATA; the slave's rvalid shows up only after reset.
      val = 1'b1; wen = 4'b0000; ren = 1'b1; adr = 32'h4000_3000; rdata = 32'h3333_3333;
      tick();
      check("rst_mid_arvalid", o_arvalid, 1'b1);
      arready = 1'b1;
      tick();
      check("rst_mid_rready", o_rready, 1'b1);
      arready = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; val = 1'b0; rvalid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         check($sformatf("rst_mid_no_rdy_c%0d", c), hs_rdy, 1'b0);
         tick();
      end
      check_all_zero("rst_mid");
      rvalid = 1'b0;
      tick();

      // Error responses: completion is unaffected; the sticky flag exists only with the option.
      ve = '{32'h4000_4000, 32'h0, 4'b0000, 1'b1, 32'h0E0E_0E0E, 0, 0, 0, 0, 0, 3, 0, 0, 1, 32'h0E0E_0E0E};
      rresp_drv = 2'b10;
      run_txn(ve, "err_rd");
      rresp_drv = 2'b00;
`ifdef CIRNO9_AXIM_ERR_EN
      check("err_set", o_bus_err, 1'b1);
`endif
      ve = '{32'h4000_4004, 32'hF00D_F00D, 4'b1111, 1'b0, 32'h0, 0, 0, 0, 0, 0, 3, 1, 1, 0, 32'h0E0E_0E0E};
      run_txn(ve, "err_wr_ok");
`ifdef CIRNO9_AXIM_ERR_EN
      check("err_sticky", o_bus_err, 1'b1);
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_all_zero("final_reset");
`ifdef CIRNO9_AXIM_ERR_EN
      check("err_cleared", o_bus_err, 1'b0);
`endif
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
